rrf_freelist: RTL and testbench

- Rename-register-file tag allocator, the producer side of the RRF dispatch/commit interface.
- Hands out up to two RRF tags per cycle in circular order at dispatch and drives the RRF's dpaddr/dpen pins, which clear the valid bits.
- Reclaims up to two tags per cycle at commit.
- Rewinds the allocation pointer on branch mispredict.
- Sits between the decode/rename stage and the rrf block.

---
 rtl/rrf_freelist.sv | 116 +++++++++++
 tb/tb_rrf_freelist.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rrf_freelist.sv
// rrf_freelist: rename-register-file tag allocator.
//
// Each cycle it can hand out up to two RRF tags in circular order. The tags
// go out on dpaddr1/dpaddr2, and dpen1/dpen2 mark which of them were actually
// taken. Committed entries are reclaimed in order at comptr. On a branch
// mispredict the allocation pointer is rewound to rrftagfix, and the free
// count is rebuilt from the distance between the two pointers.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   req1/req2  dispatch slot requests (req2 only counts with req1)
//   stall_dp   downstream stall, blocks allocation
//   comnum     entries committed this cycle (0..2)
//   prmiss     mispredict recovery, rrftagfix = pointer to restore
//   alloc_ok   enough free entries for the current request
//   dpaddr1/2  tags offered to slots 1/2 (rrfptr, rrfptr+1)
//   dpen1/2    tag allocated this cycle
//   rrfptr     next tag to allocate
//   comptr     oldest un-committed tag
//   freenum    free entry count, 0..RRF_NUM
//   rrfcyc     wrap bit of rrfptr, used for age compare
//
// Optional feature: define RRF_ALLOC_BYPASS_EN so that entries committed in
// the current cycle can be reused by the dispatch of that same cycle.
module rrf_freelist #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req1,
  input  logic               req2,
  input  logic               stall_dp,
  input  logic [1:0]         comnum,
  input  logic               prmiss,
  input  logic [RRF_SEL-1:0] rrftagfix,
  output logic               alloc_ok,
  output logic [RRF_SEL-1:0] dpaddr1,
  output logic [RRF_SEL-1:0] dpaddr2,
  output logic               dpen1,
  output logic               dpen2,
  output logic [RRF_SEL-1:0] rrfptr,
  output logic [RRF_SEL-1:0] comptr,
  output logic [RRF_SEL:0]   freenum,
  output logic               rrfcyc
);

  localparam logic [RRF_SEL:0] FULL = (RRF_SEL+1)'(RRF_NUM);

  // After a rewind, the in-flight entries are the ones from the new commit
  // pointer up to the restored allocation pointer. Everything else is free.
  // Because RRF_NUM is a power of two, the modular distance is just a
  // truncated subtraction. When the two pointers are equal, the distance is
  // zero and the file is empty.
  function automatic logic [RRF_SEL:0] free_after_fix(
    input logic [RRF_SEL-1:0] fix_ptr,
    input logic [RRF_SEL-1:0] com_ptr
  );
    logic [RRF_SEL-1:0] occ;
    occ = fix_ptr - com_ptr;
    return FULL - {1'b0, occ};
  endfunction

  logic [1:0]         reqnum;
  logic [1:0]         alloc;
  logic [RRF_SEL:0]   ptr_sum;
  logic [RRF_SEL-1:0] comptr_nxt;
  logic [RRF_SEL:0]   freenum_norm;

  assign reqnum = {1'b0, req1} + {1'b0, req1 & req2};

`ifdef RRF_ALLOC_BYPASS_EN
  logic [RRF_SEL+1:0] avail;
  assign avail    = {1'b0, freenum} + (RRF_SEL+2)'(comnum);
  assign alloc_ok = avail >= (RRF_SEL+2)'(reqnum);
`else
  assign alloc_ok = freenum >= (RRF_SEL+1)'(reqnum);
`endif

  // The whole request either fits or nothing is granted, because dpen2
  // depends on dpen1 and alloc_ok already covers the pair.
  assign dpen1   = req1 & alloc_ok & ~stall_dp & ~prmiss;
  assign dpen2   = dpen1 & req2;
  assign dpaddr1 = rrfptr;
  assign dpaddr2 = rrfptr + RRF_SEL'(1);

  assign alloc        = {1'b0, dpen1} + {1'b0, dpen2};
  // The carry out of the power-of-two pointer is exactly the wrap event.
  assign ptr_sum      = {1'b0, rrfptr} + (RRF_SEL+1)'(alloc);
  assign comptr_nxt   = comptr + RRF_SEL'(comnum);
  assign freenum_norm = freenum - (RRF_SEL+1)'(alloc) + (RRF_SEL+1)'(comnum);

  // State update: reset first, then mispredict rewind, then normal flow
  always_ff @(posedge clk) begin
    if (!reset) begin
      rrfptr  <= '0;
      comptr  <= '0;
      freenum <= FULL;
      rrfcyc  <= 1'b0;
    end else if (prmiss) begin
      rrfptr  <= rrftagfix;
      comptr  <= comptr_nxt;
      freenum <= free_after_fix(rrftagfix, comptr_nxt);
      // A restore point above the current pointer means the rewind
      // crosses back over a wrap.
      if (rrftagfix > rrfptr) rrfcyc <= ~rrfcyc;
    end else begin
      rrfptr  <= ptr_sum[RRF_SEL-1:0];
      comptr  <= comptr_nxt;
      freenum <= freenum_norm;
      if (ptr_sum[RRF_SEL]) rrfcyc <= ~rrfcyc;
    end
  end

endmodule

// File: tb/tb_rrf_freelist.sv
// Directed testbench for rrf_freelist, configured with RRF_NUM=8.
module tb_rrf_freelist;

  logic       clk = 1'b0;
  logic       reset;
  logic       req1, req2, stall_dp, prmiss;
  logic [1:0] comnum;
  logic [2:0] rrftagfix;
  logic       alloc_ok, dpen1, dpen2, rrfcyc;
  logic [2:0] dpaddr1, dpaddr2, rrfptr, comptr;
  logic [3:0] freenum;

  int n_checks = 0;
  int n_errors = 0;

  rrf_freelist #(.RRF_NUM(8), .RRF_SEL(3)) dut (
    .clk(clk), .reset(reset), .req1(req1), .req2(req2), .stall_dp(stall_dp),
    .comnum(comnum), .prmiss(prmiss), .rrftagfix(rrftagfix),
    .alloc_ok(alloc_ok), .dpaddr1(dpaddr1), .dpaddr2(dpaddr2),
    .dpen1(dpen1), .dpen2(dpen2), .rrfptr(rrfptr), .comptr(comptr),
    .freenum(freenum), .rrfcyc(rrfcyc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int p, input int c, input int f, input int y);
    chk({tag, ".rrfptr"},  32'(rrfptr),  32'(p));
    chk({tag, ".comptr"},  32'(comptr),  32'(c));
    chk({tag, ".freenum"}, 32'(freenum), 32'(f));
    chk({tag, ".rrfcyc"},  32'(rrfcyc),  32'(y));
  endtask

  task automatic idle();
    req1 = 0; req2 = 0; stall_dp = 0; prmiss = 0; comnum = 0; rrftagfix = 0;
  endtask

  initial begin
    idle();
    reset = 0;
    repeat (2) step();
    reset = 1;
    #1;
    // 1. reset state
    chk_state("rst", 0, 0, 8, 0);
    chk("rst.alloc_ok", 32'(alloc_ok), 1);
    chk("rst.dpen1", 32'(dpen1), 0);
    chk("rst.dpen2", 32'(dpen2), 0);

    // 2. four pair allocations fill the file
    for (int i = 0; i < 4; i++) begin
      req1 = 1; req2 = 1;
      #1;
      chk("fill.dpaddr1", 32'(dpaddr1), 32'(2*i));
      chk("fill.dpaddr2", 32'(dpaddr2), 32'(2*i+1));
      chk("fill.dpen1", 32'(dpen1), 1);
      chk("fill.dpen2", 32'(dpen2), 1);
      if (i == 3) chk("fill.cyc_before_wrap", 32'(rrfcyc), 0);
      step();
    end
    chk_state("full", 0, 0, 0, 1);
    #1;
    chk("full.alloc_ok", 32'(alloc_ok), 0);
    chk("full.dpen1", 32'(dpen1), 0);
    chk("full.dpen2", 32'(dpen2), 0);
    req1 = 0; req2 = 0;
    #1;
    chk("full.empty_req_ok", 32'(alloc_ok), 1);
    step();
    chk_state("full_hold", 0, 0, 0, 1);

    // 3. commit two while requesting a pair from full
    req1 = 1; req2 = 1; comnum = 2;
    #1;
`ifdef RRF_ALLOC_BYPASS_EN
    chk("byp.alloc_ok", 32'(alloc_ok), 1);
    chk("byp.dpen2", 32'(dpen2), 1);
    chk("byp.dpaddr1", 32'(dpaddr1), 0);
    chk("byp.dpaddr2", 32'(dpaddr2), 1);
    step();
    comnum = 0; req1 = 0; req2 = 0;
    chk_state("byp.after", 2, 2, 0, 1);
`else
    chk("nobyp.alloc_ok", 32'(alloc_ok), 0);
    chk("nobyp.dpen1", 32'(dpen1), 0);
    step();
    comnum = 0;
    chk_state("nobyp.freed", 0, 2, 2, 1);
    #1;
    chk("nobyp.dpen2", 32'(dpen2), 1);
    chk("nobyp.dpaddr1", 32'(dpaddr1), 0);
    chk("nobyp.dpaddr2", 32'(dpaddr2), 1);
    step();
    req1 = 0; req2 = 0;
    chk_state("nobyp.after", 2, 2, 0, 1);
`endif

    // 4. one free entry: pair refused, single granted
    comnum = 1;
    step();
    comnum = 0;
    chk_state("one_free", 2, 3, 1, 1);
    req1 = 1; req2 = 1;
    #1;
    chk("one.pair_ok", 32'(alloc_ok), 0);
    chk("one.pair_dpen1", 32'(dpen1), 0);
    chk("one.pair_dpen2", 32'(dpen2), 0);
    req2 = 0;
    #1;
    chk("one.single_dpen1", 32'(dpen1), 1);
    chk("one.single_addr", 32'(dpaddr1), 2);
    step();
    req1 = 0;
    chk_state("one.after", 3, 3, 0, 1);

    // reset overrides a simultaneous mispredict and commit
    reset = 0; prmiss = 1; comnum = 2; rrftagfix = 5;
    step();
    reset = 1; prmiss = 0; comnum = 0; rrftagfix = 0;
    chk_state("rst_mid", 0, 0, 8, 0);

    // 5. build rrfptr=6, comptr=2, freenum=4, then mispredict
    req1 = 1; req2 = 1;
    repeat (3) step();
    req1 = 0; req2 = 0; comnum = 2;
    step();
    comnum = 0;
    chk_state("pre_miss", 6, 2, 4, 0);
    prmiss = 1; rrftagfix = 4; comnum = 1; req1 = 1;
    #1;
    chk("miss.dpen1", 32'(dpen1), 0);
    step();
    prmiss = 0; comnum = 0;
    chk_state("miss", 4, 3, 7, 0);

    // 6. stall blocks allocation; release with a simultaneous commit
    stall_dp = 1;
    #1;
    chk("stall.dpen1", 32'(dpen1), 0);
    step();
    chk("stall.rrfptr", 32'(rrfptr), 4);
    stall_dp = 0; comnum = 1;
    #1;
    chk("unstall.dpen1", 32'(dpen1), 1);
    chk("unstall.addr", 32'(dpaddr1), 4);
    step();
    req1 = 0; comnum = 0;
    chk_state("unstall", 5, 4, 7, 0);

    // rewind to a restore point above rrfptr toggles the wrap bit
    prmiss = 1; rrftagfix = 7;
    step();
    chk_state("miss_wrap", 7, 4, 5, 1);
    // restoring to comptr leaves an empty file
    rrftagfix = 4;
    step();
    prmiss = 0;
    chk_state("miss_empty", 4, 4, 8, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
